// File: rtl/usr_link_pkg.sv
`default_nettype none
// ============================================================================
// Module : usr_link_pkg
// Brief  : Shared constants and types for the usr serial link (tx and rx).
// Rev    : 1.0  initial release
// ============================================================================
package usr_link_pkg;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

endpackage : usr_link_pkg
`default_nettype wire

// File: rtl/usr_sipo_core.sv
`default_nettype none
// ============================================================================
// Module : usr_sipo_core
// Brief  : Serial-in shift register with frame bit counter; flags the last bit.
// Rev    : 1.0  initial release
// ============================================================================
module usr_sipo_core
    import usr_link_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_shift_en,
    input  logic             i_dir,
    input  logic             i_s_in,
    output logic [WIDTH-1:0] o_word,
    output logic             o_done,
    output logic [CNT_W-1:0] o_bit_cnt
);

    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_next_sr;
    logic             w_last;

    assign w_next_sr = (i_dir == DIR_LEFT) ? {r_sr[WIDTH-2:0], i_s_in}
                                           : {i_s_in, r_sr[WIDTH-1:1]};
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    // o_word already contains the bit being sampled, so the parent can
    // capture the full word on the same edge that finishes the frame.
    assign o_word    = w_next_sr;
    assign o_done    = i_shift_en & ~i_clr & w_last;
    assign o_bit_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_shift_en) begin
            r_sr  <= w_next_sr;
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule : usr_sipo_core
`default_nettype wire

// File: rtl/usr_serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module : usr_serial_deserializer
// Brief  : Collects WIDTH serial bits into a word offered on a valid/ready port.
// Rev    : 1.0  initial release
// ============================================================================
module usr_serial_deserializer
    import usr_link_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             dir,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             out_valid,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun
);

    rx_state_t        r_state;
    logic             r_dir;
    logic [WIDTH-1:0] r_q;
    logic             r_out_valid;
    logic             r_overrun;

    logic             w_eff_dir;
    logic             w_shift_en;
    logic             w_done;
    logic             w_xfer;
    logic [WIDTH-1:0] w_word;
    logic [CNT_W-1:0] w_bit_cnt;

    // The first bit of a frame uses the live dir; later bits use the latched one.
    assign w_eff_dir  = (r_state == IDLE) ? dir : r_dir;
    assign w_shift_en = s_valid & ~clr;
    assign w_xfer     = r_out_valid & out_ready;

    usr_sipo_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (clr),
        .i_shift_en (w_shift_en),
        .i_dir      (w_eff_dir),
        .i_s_in     (s_in),
        .o_word     (w_word),
        .o_done     (w_done),
        .o_bit_cnt  (w_bit_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_dir   <= DIR_RIGHT;
        end else if (clr) begin
            r_state <= IDLE;
        end else if (s_valid) begin
            if (r_state == IDLE) begin
                r_dir   <= dir;
                r_state <= RECV;
            end
            if (w_done) begin
                r_state <= IDLE;
            end
        end
    end

    // A finished word loads only if the holding register is free or being
    // emptied on this same edge; otherwise it is dropped and flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q         <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_done && (!r_out_valid || out_ready)) begin
                r_q         <= w_word;
                r_out_valid <= 1'b1;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end

            if (clr) begin
                r_overrun <= 1'b0;
            end else if (w_done && r_out_valid && !out_ready) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign q         = r_q;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;
    assign bit_cnt   = w_bit_cnt;
    assign busy      = (w_bit_cnt != '0);

endmodule : usr_serial_deserializer
`default_nettype wire
